// File: rtl/cfg_bus_arbiter.sv
// Round-robin arbiter sharing one configuration port between the Wishbone-side (0) and
// SPI-side (1) requesters, one transaction in flight, with a response timeout.
module cfg_bus_arbiter #(
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_val,
    output logic              req0_rdy,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              resp0_val,
    input  logic              resp0_rdy,
    output logic [DATA_W-1:0] resp0_rdata,
    output logic              resp0_err,
    input  logic              req1_val,
    output logic              req1_rdy,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              resp1_val,
    input  logic              resp1_rdy,
    output logic [DATA_W-1:0] resp1_rdata,
    output logic              resp1_err,
    output logic              cfg_req_val,
    input  logic              cfg_req_rdy,
    output logic              cfg_we,
    output logic [ADDR_W-1:0] cfg_addr,
    output logic [DATA_W-1:0] cfg_wdata,
    input  logic              cfg_resp_val,
    input  logic [DATA_W-1:0] cfg_resp_rdata,
    output logic              grant_id,
    output logic              busy
);

    localparam int unsigned CntW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntMax  = {CntW{1'b1}};
    // Timeout fires in the WAIT cycle where the incremented count would reach TIMEOUT.
    localparam logic [CntW-1:0] CntLast = (TIMEOUT == 0) ? '0 : CntW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e            state_q, state_d;
    logic              ptr_q, ptr_d;
    logic              grant_q, grant_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    logic win_val;
    logic win_id;
    logic resp_rdy_sel;

    always_comb begin
        win_val = 1'b0;
        win_id  = ptr_q;
        if (ptr_q ? req1_val : req0_val) begin
            win_val = 1'b1;
            win_id  = ptr_q;
        end else if (ptr_q ? req0_val : req1_val) begin
            win_val = 1'b1;
            win_id  = ~ptr_q;
        end
    end

    assign resp_rdy_sel = grant_q ? resp1_rdy : resp0_rdy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            ptr_q   <= 1'b0;
            grant_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (win_val) begin
                    state_d = StIssue;
                    grant_d = win_id;
                    we_d    = win_id ? req1_we    : req0_we;
                    addr_d  = win_id ? req1_addr  : req0_addr;
                    wdata_d = win_id ? req1_wdata : req0_wdata;
                end
            end
            StIssue: begin
                if (cfg_req_rdy) begin
                    state_d = StWait;
                    cnt_d   = '0;
                end
            end
            StWait: begin
                cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
                // A response in the timeout cycle wins over the timeout.
                if (cfg_resp_val) begin
                    rdata_d = we_q ? '0 : cfg_resp_rdata;
                    err_d   = 1'b0;
                    state_d = StResp;
                end else if (TIMEOUT != 0 && cnt_q == CntLast) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = StResp;
                end
            end
            StResp: begin
                if (resp_rdy_sel) begin
                    state_d = StIdle;
                    ptr_d   = ~grant_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        req0_rdy    = 1'b0;
        req1_rdy    = 1'b0;
        cfg_req_val = 1'b0;
        resp0_val   = 1'b0;
        resp1_val   = 1'b0;
        unique case (state_q)
            StIdle: begin
                req0_rdy = win_val & ~win_id;
                req1_rdy = win_val & win_id;
            end
            StIssue: cfg_req_val = 1'b1;
            StResp: begin
                resp0_val = ~grant_q;
                resp1_val = grant_q;
            end
            default: ;
        endcase
    end

    assign busy        = (state_q != StIdle);
    assign grant_id    = grant_q;
    assign cfg_we      = we_q;
    assign cfg_addr    = addr_q;
    assign cfg_wdata   = wdata_q;
    assign resp0_rdata = rdata_q;
    assign resp1_rdata = rdata_q;
    assign resp0_err   = err_q & resp0_val;
    assign resp1_err   = err_q & resp1_val;

endmodule

// File: tb/tb_cfg_bus_arbiter.sv
// Randomized bench for cfg_bus_arbiter: a driver pushes predicted transactions into a
// scoreboard queue and a negedge monitor compares every cycle of DUT behaviour against it.
module tb_cfg_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req0_val = 0, req0_we = 0, resp0_rdy = 0;
    logic [3:0]  req0_addr = 0;
    logic [31:0] req0_wdata = 0;
    logic        req1_val = 0, req1_we = 0, resp1_rdy = 0;
    logic [3:0]  req1_addr = 0;
    logic [31:0] req1_wdata = 0;
    logic        cfg_req_rdy = 0, cfg_resp_val = 0;
    logic [31:0] cfg_resp_rdata = 0;
    logic        req0_rdy, resp0_val, resp0_err, req1_rdy, resp1_val, resp1_err;
    logic [31:0] resp0_rdata, resp1_rdata, cfg_wdata;
    logic        cfg_req_val, cfg_we, grant_id, busy;
    logic [3:0]  cfg_addr;

    cfg_bus_arbiter #(.ADDR_W(4), .DATA_W(32), .TIMEOUT(15)) dut (
        .clk(clk), .reset(reset),
        .req0_val(req0_val), .req0_rdy(req0_rdy), .req0_we(req0_we), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .resp0_val(resp0_val), .resp0_rdy(resp0_rdy),
        .resp0_rdata(resp0_rdata), .resp0_err(resp0_err),
        .req1_val(req1_val), .req1_rdy(req1_rdy), .req1_we(req1_we), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .resp1_val(resp1_val), .resp1_rdy(resp1_rdy),
        .resp1_rdata(resp1_rdata), .resp1_err(resp1_err),
        .cfg_req_val(cfg_req_val), .cfg_req_rdy(cfg_req_rdy), .cfg_we(cfg_we),
        .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_resp_val(cfg_resp_val),
        .cfg_resp_rdata(cfg_resp_rdata), .grant_id(grant_id), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          port;
        logic        we;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          iss_cyc;
        int          iss_last;
        int          resp_cyc;
    } exp_t;

    exp_t        expq[$];
    exp_t        me;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    bit          abort = 0;
    int          ptr = 0;
    bit          pv[2];
    logic        pwe[2];
    logic [3:0]  paddr[2];
    logic [31:0] pwd[2];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s at cycle %0d: actual=0x%0h required=0x%0h", name, cyc, act, req);
        end
    endtask

    initial forever begin
        @(posedge clk); #1;
        resp0_rdy = ($urandom_range(0, 3) != 0);
        resp1_rdy = ($urandom_range(0, 3) != 0);
    end

    // Scoreboard monitor: expected activity derived purely from the queued transaction.
    always @(negedge clk) begin
        if (reset) begin
            if (expq.size() == 0) begin
                chk("idle_cfg_val", 64'(cfg_req_val), 0);
                chk("idle_resp_val", 64'({resp0_val, resp1_val}), 0);
            end else begin
                me = expq[0];
                chk("cfg_req_val", 64'(cfg_req_val), 64'(cyc >= me.iss_cyc && cyc <= me.iss_last));
                chk("busy", 64'(busy), 64'(cyc >= me.iss_cyc));
                chk("resp0_val", 64'(resp0_val), 64'(me.port == 0 && cyc >= me.resp_cyc));
                chk("resp1_val", 64'(resp1_val), 64'(me.port == 1 && cyc >= me.resp_cyc));
                if (cyc >= me.iss_cyc) begin
                    chk("grant_id", 64'(grant_id), 64'(me.port));
                    chk("cfg_fields", {27'b0, cfg_we, cfg_addr, cfg_wdata},
                        {27'b0, me.we, me.addr, me.wdata});
                end
                if (resp0_val || resp1_val) begin
                    chk("resp_rdata", 64'(resp1_val ? resp1_rdata : resp0_rdata), 64'(me.rdata));
                    chk("resp_err", 64'(resp1_val ? resp1_err : resp0_err), 64'(me.err));
                    if ((resp0_val && resp0_rdy) || (resp1_val && resp1_rdy)) begin
                        void'(expq.pop_front());
                        done_cnt++;
                    end
                end
            end
        end
    end

    task automatic drive_req(input int p, input logic v, input logic we, input logic [3:0] a,
                             input logic [31:0] d);
        if (p == 0) begin
            req0_val = v; req0_we = we; req0_addr = a; req0_wdata = d;
        end else begin
            req1_val = v; req1_we = we; req1_addr = a; req1_wdata = d;
        end
    endtask

    task automatic add_req(input int p, input logic we, input logic [3:0] a, input logic [31:0] d);
        pv[p] = 1; pwe[p] = we; paddr[p] = a; pwd[p] = d;
        drive_req(p, 1'b1, we, a, d);
    endtask

    task automatic add_rand(input int p);
        if (!pv[p]) add_req(p, 1'($urandom), 4'($urandom), $urandom);
    endtask

    // k: WAIT cycle (1-based) of the target response pulse; 0 = never; 16 = after timeout.
    task automatic do_txn(input int d1, input int k, input logic [31:0] rd, input bit rst_mid);
        int   w, n, tgt;
        bit   ok;
        exp_t e;
        if (abort) return;
        w   = pv[ptr] ? ptr : 1 - ptr;
        tgt = done_cnt + 1;
        n   = 0;
        @(negedge clk);
        while (!(w == 0 ? req0_rdy : req1_rdy)) begin
            n++;
            if (n > 20) begin
                chk("accept_timeout", 1, 0);
                abort = 1;
                return;
            end
            @(negedge clk);
        end
        chk("accept_delay", 64'(n), 0);
        if (pv[1-w]) chk("loser_rdy", 64'(w == 0 ? req1_rdy : req0_rdy), 0);
        ok         = (k >= 1 && k <= 15);
        e.port     = w;
        e.we       = pwe[w];
        e.addr     = paddr[w];
        e.wdata    = pwd[w];
        e.rdata    = (ok && !pwe[w]) ? rd : 32'h0;
        e.err      = !ok;
        e.iss_cyc  = cyc + 1;
        e.iss_last = cyc + 1 + d1;
        e.resp_cyc = cyc + 2 + d1 + (ok ? k : 15);
        expq.push_back(e);
        pv[w] = 0;
        @(posedge clk); #1;
        drive_req(w, 1'($urandom_range(0, 1) & 0), 1'($urandom), 4'($urandom), $urandom);
        repeat (d1) begin @(posedge clk); #1; end
        cfg_req_rdy = 1;
        @(posedge clk); #1;
        cfg_req_rdy = 0;
        if (rst_mid) begin
            repeat (2) begin @(posedge clk); #1; end
            #2 reset = 0;
            #1;
            chk("rst_mid_outs", 64'({cfg_req_val, resp0_val, resp1_val, busy, grant_id}), 0);
            chk("rst_mid_cfg", {27'b0, cfg_we, cfg_addr, cfg_wdata}, 0);
            expq.delete();
            pv[0] = 0; pv[1] = 0; ptr = 0;
            drive_req(0, 0, 0, 0, 0);
            drive_req(1, 0, 0, 0, 0);
            @(posedge clk);
            @(negedge clk) reset = 1;
            @(posedge clk); #1;
            return;
        end
        if (k > 0) begin
            repeat (k - 1) begin @(posedge clk); #1; end
            cfg_resp_val   = 1;
            cfg_resp_rdata = rd;
            @(posedge clk); #1;
            cfg_resp_val   = 0;
            cfg_resp_rdata = $urandom;
        end
        n = 0;
        while (done_cnt != tgt) begin
            @(posedge clk);
            n++;
            if (n > 200) begin
                chk("resp_timeout", 1, 0);
                abort = 1;
                return;
            end
        end
        #1;
        ptr = 1 - w;
    endtask

    task automatic drain();
        while ((pv[0] || pv[1]) && !abort) do_txn(0, 1, $urandom, 0);
    endtask

    int d1, k, r;

    initial begin
        pv[0] = 0; pv[1] = 0;
        #12;
        chk("rst_outs", 64'({req0_rdy, req1_rdy, resp0_val, resp1_val, resp0_err, resp1_err,
                             cfg_req_val, busy, grant_id}), 0);
        chk("rst_cfg", {27'b0, cfg_we, cfg_addr, cfg_wdata}, 0);
        chk("rst_rdata", {resp0_rdata, resp1_rdata}, 0);
        @(negedge clk) reset = 1;
        @(posedge clk); #1;

        add_req(0, 1'b1, 4'h3, 32'h0000_00A5);
        do_txn(0, 1, 32'h1234_5678, 0);

        for (int i = 0; i < 4; i++) begin
            add_rand(0);
            add_rand(1);
            do_txn(0, 1, $urandom, 0);
        end
        drain();

        add_req(1, 1'b0, 4'h7, 32'h0);
        do_txn(0, 2, 32'hDEAD_BEEF, 0);
        add_req(0, 1'b0, 4'h2, 32'h0);
        do_txn(0, 0, 32'h5555_AAAA, 0);
        add_req(0, 1'b0, 4'h4, 32'h0);
        do_txn(0, 15, 32'hCAFE_F00D, 0);
        add_req(1, 1'b0, 4'h5, 32'h0);
        do_txn(2, 16, 32'h0BAD_0BAD, 0);
        add_req(1, 1'b1, 4'h9, 32'h0000_0042);
        do_txn(20, 1, 32'h7777_7777, 0);

        for (int i = 0; i < 60 && !abort; i++) begin
            if ($urandom_range(0, 1) != 0) add_rand(0);
            if ($urandom_range(0, 1) != 0) add_rand(1);
            if (pv[0] || pv[1]) begin
                r  = $urandom_range(0, 9);
                d1 = (r < 6) ? 0 : (r < 9) ? $urandom_range(1, 4) : $urandom_range(15, 20);
                r  = $urandom_range(0, 9);
                k  = (r < 5) ? $urandom_range(1, 3) : (r < 7) ? $urandom_range(4, 14) :
                     (r == 7) ? 15 : (r == 8) ? 0 : 16;
                do_txn(d1, k, $urandom, 0);
            end else begin
                @(posedge clk); #1;
            end
        end
        drain();

        if (!abort) begin
            add_req(1, 1'b0, 4'hC, 32'h0);
            do_txn(0, 0, 32'h0, 1);
            repeat (10) begin @(posedge clk); #1; end
            add_rand(1);
            add_rand(0);
            do_txn(0, 1, $urandom, 0);
            drain();
        end

        repeat (5) @(posedge clk);
        chk("queue_empty", 64'(expq.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
